project1_ir_gate_counter: RTL and testbench
===========================================

# project1_ir_gate_counter

Gated IR edge counter on the Avalon-MM bus, sitting directly downstream of `project1_gate_timer`. It consumes the timer's one-cycle timeout pulse as a gate boundary. It counts edges of the raw IR receiver input within each gate window and pushes each window's 32-bit count into a small result FIFO. Software drains the FIFO through 16-bit registers, interrupt-driven.

## Interface
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, 2..16.
- `FILTER_LEN`, 8: stable-sample cycles required by the glitch filter, 2..255; used only with the filter macro.
- `clk`  in  1: system clock. Single clock domain; no other clocks.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `chipselect`  in  1: Avalon slave select.
- `address`  in  3: register word address.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  16: write data.
- `readdata`  out  16: registered read data; reset value 0.
- `irq`  out  1: interrupt; reset value 0.
- `gate_tick`  in  1: single-cycle gate pulse, already synchronous to `clk`.
- `ir_in`  in  1: raw IR receiver output, asynchronous to `clk`.

## Operation
Register map (`address`):
- 0 STATUS
  - Read: {13'b0, enable, overflow, fifo_not_empty}.
  - Any write clears `overflow`.
- 1 CONTROL
  - Read/write bits [2:0], reset 0.
  - bit0 enable; bit1 irq_en; bit2 both_edges (0 = rising edges only, 1 = rising and falling).
- 2 DATA_L
  - Read: count[15:0] of the FIFO head; 0 when empty.
  - Writes ignored.
- 3 DATA_H
  - Read: count[31:16] of the FIFO head; 0 when empty.
  - Any write pops the head. A pop on an empty FIFO is ignored.
- 4 LEVEL
  - Read: number of FIFO entries, zero-extended.
  - Writes ignored.
- 5–7: read 0; writes ignored.

Input path:
- `ir_in` passes through a 2-FF synchronizer, then an edge detector.

Edge counter (32 bits):
- Increments on each qualifying edge while enable = 1.
- Saturates at 0xFFFFFFFF; it never wraps.

Gate handling, when `gate_tick` = 1 and enable = 1:
- The current count is pushed to the FIFO.
- The counter restarts at 0, or at 1 if a qualifying edge occurs in the same cycle. That edge belongs to the new window.

Enable behaviour:
- enable = 0: the counter is held at 0 and `gate_tick` is ignored. FIFO contents and `overflow` are preserved.
- A 0→1 transition of enable starts counting from 0. The first captured window is partial; software discards it.

FIFO boundary rules:
- Push when full: the new sample is dropped and `overflow` sets sticky.
- Push and pop in the same cycle when full: the pop happens first, the push succeeds, and `overflow` is unchanged.
- Push and pop in the same cycle when empty: the FIFO goes to 1 entry, and the pop is ignored.

`irq` = fifo_not_empty & irq_en. It is combinational from registered state.

## Timing
- Read latency: 1 cycle. `readdata` is registered every cycle from the address mux, whatever the chipselect state.
- CONTROL writes take effect on the following cycle.
- `ir_in` transition to counter increment: 3 cycles (2 sync + 1 edge register) with the filter out. With the filter in, this becomes 3 + FILTER_LEN cycles.
- `gate_tick` in cycle N: the entry is visible in LEVEL, and `irq` rises, from cycle N+1.
- DATA_H pop write in cycle N: the new head is readable from reads issued in cycle N+1.
- Minimum resolvable `ir_in` pulse width: 2 `clk` periods without the filter, FILTER_LEN + 1 with it.
- Reset mid-operation clears every register: counter, FIFO pointers, `overflow`, CONTROL, `readdata`, synchronizer and filter state.

## Configuration
- `IR_GLITCH_FILTER_EN` defined:
  - A FILTER_LEN-cycle stability filter sits between the synchronizer and the edge detector.
  - The filtered level changes only after the synchronized input has held a new value for FILTER_LEN consecutive cycles.
  - The filter resets to level 0.
- Not defined: the synchronizer output feeds the edge detector directly, and FILTER_LEN is unused.

## Structure
- Shared package `project1_ir_pkg`:
  - Register address constants (ADDR_STATUS..ADDR_LEVEL).
  - CONTROL bit indices.
  - STATUS bit indices.
  - Default FIFO_DEPTH and FILTER_LEN.
- One sub-module, `project1_ir_sample_fifo`:
  - 32-bit wide, FIFO_DEPTH deep.
  - Synchronous push/pop; show-ahead head output.
  - Outputs: level, full, empty, overflow.
- Top level holds: synchronizer, optional filter, edge detector, counter, register file, read mux.

## Test plan
- enable=1, both_edges=0; 5 rising `ir_in` pulses of 10 cycles each; `gate_tick` → LEVEL=1, DATA_L=5, DATA_H=0, STATUS=0b101.
- both_edges=1, 5 full pulses, `gate_tick` → DATA_L=10. Then write ADDR_DATA_H → LEVEL=0 and `irq` falls on the next cycle.
- FIFO_DEPTH=4, 5 gate_ticks with no pops → LEVEL=4, overflow=1, head holds window 1. A STATUS write clears overflow while LEVEL stays 4.
- Qualifying edge and `gate_tick` in the same cycle → the pushed count excludes that edge, and the next window's count includes it.
- Filter in, FILTER_LEN=8: a 5-cycle glitch is not counted, while a 20-cycle pulse is counted once. Filter out: the same 5-cycle glitch counts 1.
- enable=0 with 3 gate_ticks → LEVEL=0. Assert reset_n low mid-window while counting → all reads return 0 and `irq`=0 after release.

Source files
------------

// File: rtl/project1_ir_pkg.sv
// ---------------------------------------------------------------------------
// project1_ir_pkg
// Shared constants for the gated IR edge counter.
//
// Contents:
//   - Avalon register word addresses (ADDR_STATUS .. ADDR_LEVEL)
//   - CONTROL and STATUS bit positions
//   - Default FIFO depth and glitch filter length
//   - qualify_edge(): picks which edges of the conditioned IR level count
// ---------------------------------------------------------------------------
package project1_ir_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_DATA_L  = 3'd2;
    localparam logic [2:0] ADDR_DATA_H  = 3'd3;
    localparam logic [2:0] ADDR_LEVEL   = 3'd4;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_IRQ_EN     = 1;
    localparam int CTRL_BOTH_EDGES = 2;
    localparam int CTRL_W          = 3;

    localparam int STAT_NOT_EMPTY  = 0;
    localparam int STAT_OVERFLOW   = 1;
    localparam int STAT_ENABLE     = 2;

    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_FILTER_LEN = 8;

    localparam int COUNT_W = 32;

    // Rising edges always qualify; falling edges only in both-edges mode.
    function automatic logic qualify_edge(input logic level,
                                          input logic prev,
                                          input logic both);
        return (level & ~prev) | (both & ~level & prev);
    endfunction

endpackage

// File: rtl/project1_ir_gate_counter_if.sv
// ---------------------------------------------------------------------------
// project1_ir_gate_counter_if
// Avalon-MM slave bus of the gated IR edge counter.
//
// Signals:
//   chipselect  slave select
//   address     register word address (3 bits)
//   write_n     active-low write strobe
//   writedata   16-bit write data
//   readdata    16-bit registered read data (driven by the slave)
// Modports: master (bus driver), slave (counter block).
// ---------------------------------------------------------------------------
interface project1_ir_gate_counter_if;

    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/project1_ir_sample_fifo.sv
// ---------------------------------------------------------------------------
// project1_ir_sample_fifo
// Small show-ahead FIFO holding one count per gate window.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, push_data  write request and data
//   pop              remove head (ignored when empty)
//   clr_overflow     clear the sticky overflow flag
//   head             current head entry (0 when empty after reset)
//   level            number of stored entries
//   full, empty      occupancy flags
//   overflow         sticky: a push was dropped because the FIFO was full
//
// Same-cycle push+pop: the pop is applied first, so a full FIFO accepts the
// push, and an empty FIFO ignores the pop and takes the push.
// ---------------------------------------------------------------------------
module project1_ir_sample_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clr_overflow,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             overflow_reg;

    logic do_push;
    logic do_pop;

    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_reg + LW'(do_push) - LW'(do_pop);
            // A dropped sample outranks a simultaneous clear.
            if (push && !do_push)  overflow_reg <= 1'b1;
            else if (clr_overflow) overflow_reg <= 1'b0;
        end
    end

    assign head     = mem_reg[rd_ptr_reg];
    assign level    = level_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/project1_ir_gate_counter.sv
// ---------------------------------------------------------------------------
// project1_ir_gate_counter
// Counts edges of the raw IR input inside each window delimited by the
// gate_tick pulse from project1_gate_timer, and queues one 32-bit count per
// window in a FIFO that software drains through 16-bit registers.
//
// Ports:
//   clk        system clock (only clock)
//   reset_n    asynchronous active-low reset
//   bus        Avalon-MM slave (chipselect/address/write_n/writedata/readdata)
//   irq        fifo_not_empty & irq_en
//   gate_tick  one-cycle window boundary, synchronous to clk
//   ir_in      raw IR receiver output, asynchronous
//
// Build option: define IR_GLITCH_FILTER_EN to insert a FILTER_LEN-cycle
// stability filter between the synchronizer and the edge detector.
// Without it FILTER_LEN has no effect.
// ---------------------------------------------------------------------------
module project1_ir_gate_counter
    import project1_ir_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic                       clk,
    input  logic                       reset_n,
    project1_ir_gate_counter_if.slave  bus,
    output logic                       irq,
    input  logic                       gate_tick,
    input  logic                       ir_in
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    generate
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_param_check
            $error("project1_ir_gate_counter: FIFO_DEPTH or FILTER_LEN out of range");
        end
    endgenerate

    // ---------------- input conditioning ----------------
    logic sync1_reg;
    logic sync2_reg;
    logic ir_level;
    logic prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= ir_in;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef IR_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN);

    logic           filt_level_reg;
    logic [FCW-1:0] filt_cnt_reg;

    // The filtered level follows the synchronized input only once the new
    // value has been seen on FILTER_LEN consecutive cycles; any return to the
    // current level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_level_reg <= 1'b0;
            filt_cnt_reg   <= '0;
        end else if (sync2_reg == filt_level_reg) begin
            filt_cnt_reg <= '0;
        end else if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
            filt_level_reg <= sync2_reg;
            filt_cnt_reg   <= '0;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
    end

    assign ir_level = filt_level_reg;
`else
    assign ir_level = sync2_reg;
`endif

    // Edge register: tracks the conditioned level even while disabled so
    // that enabling never manufactures a spurious edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_reg <= 1'b0;
        else          prev_reg <= ir_level;
    end

    // ---------------- register file ----------------
    logic [CTRL_W-1:0] control_reg;
    logic              wr_en;
    logic              pop_req;
    logic              clr_overflow;
    logic              enable;
    logic              qualify;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign pop_req      = wr_en && (bus.address == ADDR_DATA_H);
    assign clr_overflow = wr_en && (bus.address == ADDR_STATUS);
    assign enable       = control_reg[CTRL_ENABLE];
    assign qualify      = qualify_edge(ir_level, prev_reg, control_reg[CTRL_BOTH_EDGES]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            control_reg <= '0;
        else if (wr_en && (bus.address == ADDR_CONTROL))
            control_reg <= bus.writedata[CTRL_W-1:0];
    end

    // ---------------- window counter ----------------
    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;
    logic               push_req;

    // At a gate boundary the finished window is queued and an edge arriving
    // in the same cycle is credited to the new window.
    always_comb begin
        count_next = count_reg;
        push_req   = 1'b0;
        if (!enable) begin
            count_next = '0;
        end else if (gate_tick) begin
            push_req   = 1'b1;
            count_next = qualify ? COUNT_W'(1) : '0;
        end else if (qualify && (count_reg != '1)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count_reg <= '0;
        else          count_reg <= count_next;
    end

    // ---------------- result FIFO ----------------
    logic [COUNT_W-1:0] fifo_head;
    logic [LW-1:0]      fifo_level;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_overflow;

    project1_ir_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (COUNT_W)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push_req),
        .push_data    (count_reg),
        .pop          (pop_req),
        .clr_overflow (clr_overflow),
        .head         (fifo_head),
        .level        (fifo_level),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow     (fifo_overflow)
    );

    // ---------------- read mux ----------------
    logic [15:0] status_word;
    logic [15:0] head_lo;
    logic [15:0] head_hi;
    logic [15:0] readdata_next;

    // Head bits are forced to 0 when empty so stale entries never leak out.
    assign head_lo = fifo_empty ? 16'h0 : fifo_head[15:0];
    assign head_hi = fifo_empty ? 16'h0 : fifo_head[31:16];

    always_comb begin
        status_word                 = '0;
        status_word[STAT_NOT_EMPTY] = ~fifo_empty;
        status_word[STAT_OVERFLOW]  = fifo_overflow;
        status_word[STAT_ENABLE]    = enable;
    end

    always_comb begin
        readdata_next = '0;
        case (bus.address)
            ADDR_STATUS:  readdata_next = status_word;
            ADDR_CONTROL: readdata_next = 16'(control_reg);
            ADDR_DATA_L:  readdata_next = head_lo;
            ADDR_DATA_H:  readdata_next = head_hi;
            ADDR_LEVEL:   readdata_next = 16'(fifo_level);
            default:      readdata_next = '0;
        endcase
    end

    // Registered every cycle regardless of chipselect: one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= readdata_next;
    end

    assign irq = ~fifo_empty & control_reg[CTRL_IRQ_EN];

    // Upper write-data bits and the full flag have no consumer here.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.writedata[15:CTRL_W], fifo_full};

endmodule

// File: tb/tb_project1_ir_gate_counter.sv
module tb_project1_ir_gate_counter;
    import project1_ir_pkg::*;

    localparam int DEPTH = 4;
    localparam int FLEN  = 8;
`ifdef IR_GLITCH_FILTER_EN
    localparam int          LAT_EXTRA  = FLEN;
    localparam logic [31:0] GLITCH_CNT = 32'd0;
`else
    localparam int          LAT_EXTRA  = 0;
    localparam logic [31:0] GLITCH_CNT = 32'd1;
`endif
    localparam int SETTLE = 15;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic gate_tick = 1'b0;
    logic ir_in     = 1'b0;
    logic irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] drain_exp [4] = '{32'd2, 32'd3, 32'd4, 32'd6};

    project1_ir_gate_counter_if bus ();

    project1_ir_gate_counter #(
        .FIFO_DEPTH (DEPTH),
        .FILTER_LEN (FLEN)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .irq       (irq),
        .gate_tick (gate_tick),
        .ir_in     (ir_in)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus.chipselect = 1'b1;
        bus.address    = addr;
        bus.write_n    = 1'b0;
        bus.writedata  = data;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        $display("wr addr=%0d data=0x%0h", addr, data);
    endtask

    task automatic rd_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        bus.chipselect = 1'b1;
        bus.address    = addr;
        bus.write_n    = 1'b1;
        tick(1);
        bus.chipselect = 1'b0;
        $display("rd addr=%0d data=0x%0h (%s)", addr, bus.readdata, tag);
        check(tag, {16'h0, bus.readdata}, exp);
    endtask

    task automatic gate();
        gate_tick = 1'b1;
        tick(1);
        gate_tick = 1'b0;
        $display("gate");
    endtask

    task automatic gate_pop();
        gate_tick      = 1'b1;
        bus.chipselect = 1'b1;
        bus.address    = ADDR_DATA_H;
        bus.write_n    = 1'b0;
        tick(1);
        gate_tick      = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        $display("gate+pop");
    endtask

    task automatic pulse(input int hi, input int lo);
        ir_in = 1'b1;
        tick(hi);
        ir_in = 1'b0;
        tick(lo);
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.address    = '0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset state
        tick(3);
        check("rst_readdata", {16'h0, bus.readdata}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        tick(2);
        for (int a = 0; a < 8; a++) rd_check($sformatf("rst_rd%0d", a), 3'(a), 32'd0);

        // Rising-edge counting, one window of 5 pulses
        wr(ADDR_CONTROL, 16'h0001);
        rd_check("t1_control", ADDR_CONTROL, 32'd1);
        repeat (5) pulse(10, 10);
        tick(SETTLE);
        gate();
        check("t1_irq_masked", {31'd0, irq}, 32'd0);
        rd_check("t1_level", ADDR_LEVEL, 32'd1);
        rd_check("t1_data_l", ADDR_DATA_L, 32'd5);
        rd_check("t1_data_h", ADDR_DATA_H, 32'd0);
        rd_check("t1_status", ADDR_STATUS, 32'h5);
        wr(ADDR_DATA_H, 16'h0);
        rd_check("t1_level_pop", ADDR_LEVEL, 32'd0);

        // Both edges, irq on/off around the pop
        wr(ADDR_CONTROL, 16'h0007);
        repeat (5) pulse(10, 10);
        tick(SETTLE);
        gate();
        check("t2_irq_high", {31'd0, irq}, 32'd1);
        rd_check("t2_data_l", ADDR_DATA_L, 32'd10);
        wr(ADDR_DATA_H, 16'h0);
        check("t2_irq_low", {31'd0, irq}, 32'd0);
        rd_check("t2_level", ADDR_LEVEL, 32'd0);

        // Overflow: windows of 1..5 pulses, fifth dropped
        wr(ADDR_CONTROL, 16'h0003);
        for (int w = 1; w <= 5; w++) begin
            repeat (w) pulse(10, 10);
            tick(SETTLE);
            gate();
        end
        rd_check("t3_level_full", ADDR_LEVEL, 32'd4);
        rd_check("t3_status_ovf", ADDR_STATUS, 32'h7);
        rd_check("t3_head_w1", ADDR_DATA_L, 32'd1);
        wr(ADDR_STATUS, 16'h0);
        rd_check("t3_status_clr", ADDR_STATUS, 32'h5);
        rd_check("t3_level_kept", ADDR_LEVEL, 32'd4);

        // Push and pop together while full
        repeat (6) pulse(10, 10);
        tick(SETTLE);
        gate_pop();
        rd_check("t3_full_pp_level", ADDR_LEVEL, 32'd4);
        rd_check("t3_full_pp_status", ADDR_STATUS, 32'h5);
        for (int i = 0; i < 4; i++) begin
            rd_check($sformatf("t3_drain%0d", i), ADDR_DATA_L, drain_exp[i]);
            wr(ADDR_DATA_H, 16'h0);
        end
        rd_check("t3_drained_level", ADDR_LEVEL, 32'd0);
        rd_check("t3_empty_data_l", ADDR_DATA_L, 32'd0);
        wr(ADDR_DATA_H, 16'h0);
        rd_check("t3_empty_pop_level", ADDR_LEVEL, 32'd0);
        rd_check("t3_empty_status", ADDR_STATUS, 32'h4);

        // Push and pop together while empty
        repeat (2) pulse(10, 10);
        tick(SETTLE);
        gate_pop();
        rd_check("t3_empty_pp_level", ADDR_LEVEL, 32'd1);
        rd_check("t3_empty_pp_data", ADDR_DATA_L, 32'd2);
        wr(ADDR_DATA_H, 16'h0);

        // Edge coincident with gate belongs to the next window
        repeat (2) pulse(10, 10);
        tick(SETTLE);
        ir_in = 1'b1;
        tick(2 + LAT_EXTRA);
        gate();
        tick(10);
        ir_in = 1'b0;
        tick(SETTLE);
        gate();
        rd_check("t4_before_gate", ADDR_DATA_L, 32'd2);
        wr(ADDR_DATA_H, 16'h0);
        rd_check("t4_after_gate", ADDR_DATA_L, 32'd1);
        wr(ADDR_DATA_H, 16'h0);

        // Short glitch vs long pulse
        ir_in = 1'b1;
        tick(5);
        ir_in = 1'b0;
        tick(SETTLE);
        gate();
        rd_check("t5_glitch", ADDR_DATA_L, GLITCH_CNT);
        wr(ADDR_DATA_H, 16'h0);
        pulse(20, 10);
        tick(SETTLE);
        gate();
        rd_check("t5_long_pulse", ADDR_DATA_L, 32'd1);
        wr(ADDR_DATA_H, 16'h0);

        // Disabled: gates ignored, counter held at 0
        wr(ADDR_CONTROL, 16'h0000);
        repeat (3) begin
            pulse(10, 10);
            gate();
        end
        rd_check("t6_level", ADDR_LEVEL, 32'd0);
        rd_check("t6_status", ADDR_STATUS, 32'h0);
        wr(ADDR_CONTROL, 16'h0003);
        tick(2);
        gate();
        check("t6_irq", {31'd0, irq}, 32'd1);
        rd_check("t6_fresh_count", ADDR_DATA_L, 32'd0);
        wr(ADDR_DATA_H, 16'h0);

        // Reset in the middle of a counting window
        repeat (2) pulse(10, 10);
        tick(SETTLE);
        gate();
        check("t7_irq_pre", {31'd0, irq}, 32'd1);
        pulse(10, 10);
        ir_in = 1'b1;
        tick(4);
        reset_n = 1'b0;
        #2;
        check("t7_async_readdata", {16'h0, bus.readdata}, 32'd0);
        check("t7_async_irq", {31'd0, irq}, 32'd0);
        ir_in = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("t7_irq_post", {31'd0, irq}, 32'd0);
        for (int a = 0; a < 5; a++) rd_check($sformatf("t7_rd%0d", a), 3'(a), 32'd0);
        wr(ADDR_CONTROL, 16'h0001);
        tick(2);
        gate();
        rd_check("t7_level_new", ADDR_LEVEL, 32'd1);
        rd_check("t7_count_new", ADDR_DATA_L, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
